// File: rtl/pcie_us_cfg_mgmt_responder_pkg.sv
// Shared definitions for the cfg_mgmt responder: FSM states, Device Control
// field positions, read-only boundary default and the unsupported-function
// read value, plus the byte-enable merge helper used by the register file.
package pcie_cfg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_DONE,
    ST_GAP
  } state_e;

  localparam int MPS_LSB = 5;
  localparam int MRRS_LSB = 12;
  localparam int FIELD_WIDTH = 3;

  localparam int RO_LIMIT_DEFAULT = 4;

  localparam logic [31:0] UNSUP_READ_VALUE = 32'hFFFF_FFFF;

  // Replace only the bytes whose enable bit is set
  function automatic logic [31:0] be_merge(input logic [31:0] old_word,
                                           input logic [31:0] new_word,
                                           input logic [3:0]  be);
    logic [31:0] merged;
    merged = old_word;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) begin
        merged[8*b +: 8] = new_word[8*b +: 8];
      end
    end
    return merged;
  endfunction

endpackage

// File: rtl/pcie_us_cfg_mgmt_responder_if.sv
// cfg_mgmt bus between the core's initiator (master) and this responder
// (slave), including the decoded Device Control fields fed back to the core.
interface pcie_us_cfg_mgmt_responder_if;

  logic [9:0]  cfg_mgmt_addr;
  logic [7:0]  cfg_mgmt_function_number;
  logic        cfg_mgmt_write;
  logic [31:0] cfg_mgmt_write_data;
  logic [3:0]  cfg_mgmt_byte_enable;
  logic        cfg_mgmt_read;
  logic [31:0] cfg_mgmt_read_data;
  logic        cfg_mgmt_read_write_done;
  logic [2:0]  cfg_max_payload;
  logic [2:0]  cfg_max_read_req;

  modport master (
    output cfg_mgmt_addr,
    output cfg_mgmt_function_number,
    output cfg_mgmt_write,
    output cfg_mgmt_write_data,
    output cfg_mgmt_byte_enable,
    output cfg_mgmt_read,
    input  cfg_mgmt_read_data,
    input  cfg_mgmt_read_write_done,
    input  cfg_max_payload,
    input  cfg_max_read_req
  );

  modport slave (
    input  cfg_mgmt_addr,
    input  cfg_mgmt_function_number,
    input  cfg_mgmt_write,
    input  cfg_mgmt_write_data,
    input  cfg_mgmt_byte_enable,
    input  cfg_mgmt_read,
    output cfg_mgmt_read_data,
    output cfg_mgmt_read_write_done,
    output cfg_max_payload,
    output cfg_max_read_req
  );

endinterface

// File: rtl/pcie_us_cfg_mgmt_responder_regfile.sv
// Per-function config register file: byte-enable writes, registered reads,
// dword 0 of every function initialised to the Device/Vendor ID on reset.
// Also taps the function 0 Device Control fields straight from storage.
module pcie_cfg_regfile
  import pcie_cfg_pkg::*;
#(
  parameter int          FUNC_COUNT  = 1,
  parameter int          ADDR_WIDTH  = 6,
  parameter int          FUNC_WIDTH  = 1,
  parameter logic [31:0] ID_VALUE    = 32'h9038_10ee,
  parameter logic [9:0]  DEVCTL_ADDR = 10'h01e
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   we_i,
  input  logic                   re_i,
  input  logic [FUNC_WIDTH-1:0]  func_i,
  input  logic [ADDR_WIDTH-1:0]  addr_i,
  input  logic [31:0]            wdata_i,
  input  logic [3:0]             be_i,
  output logic [31:0]            rdata_o,
  output logic [2:0]             mps_o,
  output logic [2:0]             mrrs_o
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] DEVCTL_IDX = DEVCTL_ADDR[ADDR_WIDTH-1:0];
  localparam logic [DEPTH-1:0][31:0] FUNC_INIT = {{((DEPTH-1)*32){1'b0}}, ID_VALUE};

  logic [FUNC_COUNT-1:0][DEPTH-1:0][31:0] mem_q;
  logic [31:0] rdata_q;

  // Storage: whole array returns to its init image on reset, else byte-merged writes
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q <= {FUNC_COUNT{FUNC_INIT}};
    end else if (we_i) begin
      mem_q[func_i][addr_i] <= be_merge(mem_q[func_i][addr_i], wdata_i, be_i);
    end
  end

  // Read port is registered so data lands one cycle after the read strobe
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[func_i][addr_i];
    end
  end

  assign rdata_o = rdata_q;
  assign mps_o   = mem_q[0][DEVCTL_IDX][MPS_LSB +: FIELD_WIDTH];
  assign mrrs_o  = mem_q[0][DEVCTL_IDX][MRRS_LSB +: FIELD_WIDTH];

endmodule

// File: rtl/pcie_us_cfg_mgmt_responder.sv
// cfg_mgmt responder: captures one request, waits LATENCY cycles, performs
// it against the register file, pulses done, then ignores the bus for one
// gap cycle so a request held past done is not executed twice.
module pcie_us_cfg_mgmt_responder
  import pcie_cfg_pkg::*;
#(
  parameter int          FUNC_COUNT     = 1,
  parameter int          REG_ADDR_WIDTH = 6,
  parameter int          LATENCY        = 2,
  parameter logic [31:0] ID_VALUE       = 32'h9038_10ee,
  parameter int          RO_LIMIT       = RO_LIMIT_DEFAULT,
  parameter logic [9:0]  DEVCTL_ADDR    = 10'h01e
) (
  input  logic clk,
  input  logic rst,
  pcie_us_cfg_mgmt_responder_if.slave mgmt
);

  localparam int FUNC_WIDTH = (FUNC_COUNT > 1) ? $clog2(FUNC_COUNT) : 1;
  localparam logic [3:0] CNT_LOAD   = 4'(LATENCY - 1);
  localparam logic [7:0] FUNC_LIMIT = 8'(FUNC_COUNT);
  localparam logic [9:0] RO_BOUND   = 10'(RO_LIMIT);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [9:0]  addr_q;
  logic [7:0]  func_q;
  logic [31:0] wdata_q;
  logic [3:0]  be_q;
  logic        wr_q;
  logic        capture;
  logic        func_ok, addr_backed, addr_ro;
  logic        rf_we, rf_re;
  logic [31:0] rf_rdata;
  logic [31:0] resp;
  logic [2:0]  mps_tap, mrrs_tap, mps_q, mrrs_q;

  assign func_ok     = func_q < FUNC_LIMIT;
  assign addr_backed = (addr_q >> REG_ADDR_WIDTH) == '0;
  assign addr_ro     = addr_q < RO_BOUND;

  // State and latency counter; reset aborts any request in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Holding registers so bus changes after capture cannot affect the request
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q  <= '0;
      func_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      wr_q    <= 1'b0;
    end else if (capture) begin
      addr_q  <= mgmt.cfg_mgmt_addr;
      func_q  <= mgmt.cfg_mgmt_function_number;
      wdata_q <= mgmt.cfg_mgmt_write_data;
      be_q    <= mgmt.cfg_mgmt_byte_enable;
      wr_q    <= mgmt.cfg_mgmt_write;
    end
  end

  // Next state, capture strobe and register-file strobes on the last BUSY cycle
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    rf_we   = 1'b0;
    rf_re   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (mgmt.cfg_mgmt_read || mgmt.cfg_mgmt_write) begin
          capture = 1'b1;
          cnt_d   = CNT_LOAD;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (cnt_q == '0) begin
          rf_we   = wr_q && func_ok && addr_backed && !addr_ro;
          rf_re   = !wr_q && func_ok && addr_backed;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_DONE: state_d = ST_GAP;
      ST_GAP:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Read data is only driven in DONE; writes and unbacked reads return zero
  always_comb begin
    resp = '0;
    if (state_q == ST_DONE && !wr_q) begin
      if (!func_ok) begin
        resp = UNSUP_READ_VALUE;
      end else if (addr_backed) begin
        resp = rf_rdata;
      end
    end
  end

  // Device Control fields are re-registered from storage every cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      mps_q  <= '0;
      mrrs_q <= '0;
    end else begin
      mps_q  <= mps_tap;
      mrrs_q <= mrrs_tap;
    end
  end

  pcie_cfg_regfile #(
    .FUNC_COUNT  (FUNC_COUNT),
    .ADDR_WIDTH  (REG_ADDR_WIDTH),
    .FUNC_WIDTH  (FUNC_WIDTH),
    .ID_VALUE    (ID_VALUE),
    .DEVCTL_ADDR (DEVCTL_ADDR)
  ) u_regfile (
    .clk     (clk),
    .rst     (rst),
    .we_i    (rf_we),
    .re_i    (rf_re),
    .func_i  (func_q[FUNC_WIDTH-1:0]),
    .addr_i  (addr_q[REG_ADDR_WIDTH-1:0]),
    .wdata_i (wdata_q),
    .be_i    (be_q),
    .rdata_o (rf_rdata),
    .mps_o   (mps_tap),
    .mrrs_o  (mrrs_tap)
  );

  assign mgmt.cfg_mgmt_read_data       = resp;
  assign mgmt.cfg_mgmt_read_write_done = (state_q == ST_DONE);
  assign mgmt.cfg_max_payload          = mps_q;
  assign mgmt.cfg_max_read_req         = mrrs_q;

endmodule

// File: tb/tb_pcie_us_cfg_mgmt_responder.sv
// Bench for the cfg_mgmt responder: directed scenarios followed by random
// traffic, all checked against an array-based model of the config space.
module tb_pcie_us_cfg_mgmt_responder;

  localparam int          FUNC_COUNT = 2;
  localparam int          AW         = 6;
  localparam int          DEPTH      = 64;
  localparam int          LATENCY    = 2;
  localparam logic [31:0] ID         = 32'h9038_10ee;
  localparam int          RO         = 4;
  localparam logic [9:0]  DEVCTL     = 10'h01e;

  typedef struct {
    logic [31:0] rdata;
    logic [2:0]  mps;
    logic [2:0]  mrrs;
    string       tag;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   vectorCount = 0;
  int   missCount   = 0;
  exp_t expQ[$];
  logic [31:0] modelMem [FUNC_COUNT][DEPTH];

  pcie_us_cfg_mgmt_responder_if mgmt ();

  pcie_us_cfg_mgmt_responder #(
    .FUNC_COUNT     (FUNC_COUNT),
    .REG_ADDR_WIDTH (AW),
    .LATENCY        (LATENCY),
    .ID_VALUE       (ID),
    .RO_LIMIT       (RO),
    .DEVCTL_ADDR    (DEVCTL)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .mgmt (mgmt)
  );

  // Free-running clock
  always #5 clk = ~clk;

  // Config space after reset: ID in dword 0 of each function, zero elsewhere
  task automatic modelReset();
    for (int f = 0; f < FUNC_COUNT; f++)
      for (int a = 0; a < DEPTH; a++)
        modelMem[f][a] = (a == 0) ? ID : 32'h0;
  endtask

  // Expected read_data of one access, updating the model for writes
  function automatic logic [31:0] modelAccess(input logic [9:0] addr, input logic [7:0] func,
                                              input logic [31:0] wdata, input logic [3:0] be,
                                              input logic wr);
    if (wr) begin
      if (int'(func) < FUNC_COUNT && int'(addr) < DEPTH && int'(addr) >= RO)
        for (int b = 0; b < 4; b++)
          if (be[b]) modelMem[func][addr][8*b +: 8] = wdata[8*b +: 8];
      return 32'h0;
    end
    if (int'(func) >= FUNC_COUNT) return 32'hFFFF_FFFF;
    if (int'(addr) >= DEPTH) return 32'h0;
    return modelMem[func][addr];
  endfunction

  function automatic logic [31:0] devctlWord();
    return modelMem[0][int'(DEVCTL)];
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectorCount++;
    if (actual !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Issue one request, queue its expected response and check completion latency
  task automatic applyStimulus(input string tag, input logic [9:0] addr, input logic [7:0] func,
                               input logic [31:0] wdata, input logic [3:0] be,
                               input logic wr, input logic rd, input logic holdExtra);
    exp_t e;
    int   cycles;
    logic gotDone;
    logic [31:0] dw;
    e.rdata = modelAccess(addr, func, wdata, be, wr);
    dw      = devctlWord();
    e.mps   = dw[7:5];
    e.mrrs  = dw[14:12];
    e.tag   = tag;
    expQ.push_back(e);
    mgmt.cfg_mgmt_addr            = addr;
    mgmt.cfg_mgmt_function_number = func;
    mgmt.cfg_mgmt_write_data      = wdata;
    mgmt.cfg_mgmt_byte_enable     = be;
    mgmt.cfg_mgmt_write           = wr;
    mgmt.cfg_mgmt_read            = rd;
    cycles  = 0;
    gotDone = 1'b0;
    while (!gotDone && cycles < 20) begin
      @(posedge clk);
      cycles++;
      @(negedge clk);
      if (mgmt.cfg_mgmt_read_write_done) gotDone = 1'b1;
    end
    checkOutput({tag, " latency"}, 32'(cycles), 32'(LATENCY + 1));
    if (!gotDone) expQ.delete();
    if (holdExtra) repeat (2) @(negedge clk);
    mgmt.cfg_mgmt_write = 1'b0;
    mgmt.cfg_mgmt_read  = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  // Monitor: pops an expectation on every done pulse, checks fields one cycle later
  initial begin
    exp_t pend;
    logic pending;
    pending = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pending = 1'b0;
      end else if (mgmt.cfg_mgmt_read_write_done) begin
        if (expQ.size() == 0) begin
          vectorCount++;
          missCount++;
          $display("[TB] FAIL unexpected done: got 1, expected 0");
        end else begin
          pend = expQ.pop_front();
          checkOutput({pend.tag, " rdata"}, mgmt.cfg_mgmt_read_data, pend.rdata);
          pending = 1'b1;
        end
      end else if (pending) begin
        checkOutput({pend.tag, " max_payload"}, 32'(mgmt.cfg_max_payload), 32'(pend.mps));
        checkOutput({pend.tag, " max_read_req"}, 32'(mgmt.cfg_max_read_req), 32'(pend.mrrs));
        checkOutput({pend.tag, " rdata after done"}, mgmt.cfg_mgmt_read_data, 32'h0);
        pending = 1'b0;
      end
    end
  end

  // Main sequence: directed cases, mid-operation reset, then random traffic
  initial begin
    logic [9:0]  addr;
    logic [7:0]  func;
    logic [1:0]  op;
    rst = 1'b1;
    mgmt.cfg_mgmt_addr            = '0;
    mgmt.cfg_mgmt_function_number = '0;
    mgmt.cfg_mgmt_write_data      = '0;
    mgmt.cfg_mgmt_byte_enable     = '0;
    mgmt.cfg_mgmt_write           = 1'b0;
    mgmt.cfg_mgmt_read            = 1'b0;
    modelReset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("reset done", 32'(mgmt.cfg_mgmt_read_write_done), 32'h0);
    checkOutput("reset rdata", mgmt.cfg_mgmt_read_data, 32'h0);
    checkOutput("reset max_payload", 32'(mgmt.cfg_max_payload), 32'h0);
    checkOutput("reset max_read_req", 32'(mgmt.cfg_max_read_req), 32'h0);

    applyStimulus("id read", 10'h000, 8'd0, 32'h0, 4'h0, 1'b0, 1'b1, 1'b0);
    applyStimulus("devctl write", DEVCTL, 8'd0, 32'h0000_2040, 4'hF, 1'b1, 1'b0, 1'b0);
    applyStimulus("devctl read", DEVCTL, 8'd0, 32'h0, 4'h0, 1'b0, 1'b1, 1'b0);
    applyStimulus("be full write", 10'h008, 8'd0, 32'hAABB_CCDD, 4'hF, 1'b1, 1'b0, 1'b0);
    applyStimulus("be partial write", 10'h008, 8'd0, 32'h1122_3344, 4'b0101, 1'b1, 1'b0, 1'b0);
    applyStimulus("be read", 10'h008, 8'd0, 32'h0, 4'h0, 1'b0, 1'b1, 1'b0);
    applyStimulus("ro write", 10'h001, 8'd0, 32'hDEAD_BEEF, 4'hF, 1'b1, 1'b0, 1'b0);
    applyStimulus("ro read", 10'h001, 8'd0, 32'h0, 4'h0, 1'b0, 1'b1, 1'b0);
    applyStimulus("id write", 10'h000, 8'd1, 32'h1234_5678, 4'hF, 1'b1, 1'b0, 1'b0);
    applyStimulus("id f1 read", 10'h000, 8'd1, 32'h0, 4'h0, 1'b0, 1'b1, 1'b0);
    applyStimulus("unbacked write", 10'h3ff, 8'd0, 32'hCAFE_F00D, 4'hF, 1'b1, 1'b0, 1'b0);
    applyStimulus("unbacked read", 10'h3ff, 8'd0, 32'h0, 4'h0, 1'b0, 1'b1, 1'b0);
    applyStimulus("alias read", 10'h03f, 8'd0, 32'h0, 4'h0, 1'b0, 1'b1, 1'b0);
    applyStimulus("unsup func read", 10'h000, 8'd5, 32'h0, 4'h0, 1'b0, 1'b1, 1'b0);
    applyStimulus("held read", 10'h008, 8'd0, 32'h0, 4'h0, 1'b0, 1'b1, 1'b1);
    applyStimulus("rd+wr", 10'h009, 8'd1, 32'h5566_7788, 4'hF, 1'b1, 1'b1, 1'b0);
    applyStimulus("rd+wr readback", 10'h009, 8'd1, 32'h0, 4'h0, 1'b0, 1'b1, 1'b0);

    // Reset while BUSY: the request must vanish without a done pulse
    mgmt.cfg_mgmt_addr            = 10'h008;
    mgmt.cfg_mgmt_function_number = 8'd0;
    mgmt.cfg_mgmt_read            = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    mgmt.cfg_mgmt_read = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    modelReset();
    repeat (LATENCY + 3) @(negedge clk);
    checkOutput("post-reset max_payload", 32'(mgmt.cfg_max_payload), 32'h0);
    checkOutput("post-reset max_read_req", 32'(mgmt.cfg_max_read_req), 32'h0);
    applyStimulus("post-reset read 8", 10'h008, 8'd0, 32'h0, 4'h0, 1'b0, 1'b1, 1'b0);
    applyStimulus("post-reset devctl", DEVCTL, 8'd0, 32'h0, 4'h0, 1'b0, 1'b1, 1'b0);
    applyStimulus("post-reset id", 10'h000, 8'd1, 32'h0, 4'h0, 1'b0, 1'b1, 1'b0);

    for (int i = 0; i < 150; i++) begin
      case ($urandom_range(0, 9))
        0:       addr = DEVCTL;
        1:       addr = 10'($urandom);
        2:       addr = 10'($urandom_range(0, RO - 1));
        default: addr = 10'($urandom_range(0, DEPTH - 1));
      endcase
      func = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(2, 255)) : 8'($urandom_range(0, 1));
      op   = 2'($urandom_range(0, 2));
      applyStimulus("random", addr, func, $urandom, 4'($urandom), op != 2'd0, op != 2'd1,
                    $urandom_range(0, 7) == 0);
    end

    repeat (4) @(negedge clk);
    checkOutput("queue drained", 32'(expQ.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule
